// File: rtl/nv_ram_rws_512x256_fifo_ctrl_pkg.sv
// Shared constants, types and helpers for the 512x256 RAM-backed FIFO controller.
package nv_ram_rws_512x256_fifo_ctrl_pkg;

    localparam int NV_FIFO512_DW        = 256;
    localparam int NV_FIFO512_AW        = 9;
    localparam int NV_FIFO512_DEPTH     = 512;
    localparam int NV_FIFO512_CNT_W     = 10;

    // The output stage holds at most two words; together with one RAM read
    // in flight this is all the latency hiding one-transfer-per-cycle needs.
    localparam int NV_FIFO512_OUT_DEPTH = 2;

    typedef logic [1:0] out_cnt_t;

    // Prefetch admission: a new RAM read may be issued only if, after this
    // cycle's pop, the output stage plus the pending read still leave room
    // for the word the new read will return.
    function automatic logic nv_fifo512_out_room(
        input out_cnt_t out_cnt,
        input logic     inflight,
        input logic     pop
    );
        logic [2:0] occ;
        occ = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(NV_FIFO512_OUT_DEPTH);
    endfunction

endpackage

// File: rtl/nv_ram_rws_512x256.sv
// Behavioural model of the 512x256 single-read/single-write RAM: the read
// address is registered on ram_re, data appears combinationally from the
// array in the following cycle.
module nv_ram_rws_512x256 (
    input  logic         clk,
    input  logic         re,
    input  logic [8:0]   ra,
    input  logic         we,
    input  logic [8:0]   wa,
    input  logic [255:0] di,
    output logic [255:0] dout
);

    logic [255:0] mem_q [512];
    logic [8:0]   ra_q;

    // Write port and registered read address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= di;
        end
        if (re) begin
            ra_q <= ra;
        end
    end

    assign dout = mem_q[ra_q];

endmodule

// File: rtl/nv_ram_rws_512x256_fifo_ctrl_out_skid2.sv
// Two-entry in-order output queue sitting behind the RAM read port. Entry 0
// is always the head and drives the read payload directly, so the payload
// only moves when the head is popped or when the queue is empty.
module nv_fifo_out_skid2
    import nv_ram_rws_512x256_fifo_ctrl_pkg::*;
#(
    parameter int DW = NV_FIFO512_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          vld_o,
    output out_cnt_t      cnt_o
);

    logic [DW-1:0] e0_q, e0_d;
    logic [DW-1:0] e1_q, e1_d;
    out_cnt_t      cnt_q, cnt_d;

    // Next-state for the queue: push appends at the tail, pop shifts entry 1
    // into the head; both together keep occupancy constant.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d = push_data_i;
                end else begin
                    e1_d = push_data_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_data_i;
                end else begin
                    e0_d = push_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Queue storage; the payload is cleared on reset so the visible read
    // data returns to zero together with the valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o = e0_q;
    assign vld_o  = (cnt_q != 2'd0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/nv_ram_rws_512x256_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 512x256 RAM with a one-cycle
// read latency. Owns the write/read pointers and RAM occupancy, prefetches
// into a two-entry output queue so reads stream at one word per cycle.
module nv_ram_rws_512x256_fifo_ctrl
    import nv_ram_rws_512x256_fifo_ctrl_pkg::*;
#(
    parameter int DW = NV_FIFO512_DW,
    parameter int AW = NV_FIFO512_AW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_pvld,
    output logic                        wr_prdy,
    input  logic [DW-1:0]               wr_pd,
    output logic                        rd_pvld,
    input  logic                        rd_prdy,
    output logic [DW-1:0]               rd_pd,
    output logic [NV_FIFO512_CNT_W-1:0] count,
    output logic                        ram_we,
    output logic [AW-1:0]               ram_wa,
    output logic [DW-1:0]               ram_di,
    output logic                        ram_re,
    output logic [AW-1:0]               ram_ra,
    input  logic [DW-1:0]               ram_dout,
    input  logic [31:0]                 pwrbus_ram_pd,
    output logic [31:0]                 ram_pwrbus_ram_pd
);

    localparam int          CW       = NV_FIFO512_CNT_W;
    localparam logic [AW:0] RAM_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          inflight_q;
    logic [CW-1:0] count_q, count_d;

    logic          wr_acc;
    logic          pop;
    logic          rd_issue;
    out_cnt_t      out_cnt;

    // Handshakes. Reset forces the write side closed and suppresses RAM reads
    // so nothing is committed while the controller is being cleared.
    assign wr_prdy  = !rst && (ram_cnt_q != RAM_FULL);
    assign wr_acc   = wr_pvld && wr_prdy;
    assign pop      = rd_pvld && rd_prdy;
    assign rd_issue = !rst && (ram_cnt_q != '0)
                      && nv_fifo512_out_room(out_cnt, inflight_q, pop);

    // RAM drive. Pointers are only equal when the RAM is empty or full, so a
    // read and a write can never target the same address in one cycle.
    assign ram_we = wr_acc;
    assign ram_wa = wr_ptr_q;
    assign ram_di = wr_pd;
    assign ram_re = rd_issue;
    assign ram_ra = rd_ptr_q;

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    // Pointer, RAM occupancy and total-count next state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({wr_acc, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase
        // Every accepted word is held somewhere (RAM, in flight or output
        // queue) until it is popped, so the total tracks accepts minus pops.
        count_d = count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, pop};
    end

    // Controller state; an in-flight read is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= rd_issue;
            count_q    <= count_d;
        end
    end

    // RAM data is captured the one cycle it is valid, so later writes to the
    // same address cannot disturb a word already read.
    nv_fifo_out_skid2 #(
        .DW (DW)
    ) u_out (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (inflight_q),
        .push_data_i (ram_dout),
        .pop_i       (pop),
        .head_o      (rd_pd),
        .vld_o       (rd_pvld),
        .cnt_o       (out_cnt)
    );

    assign count = count_q;

endmodule

// File: tb/tb_nv_ram_rws_512x256_fifo_ctrl.sv
// Scoreboard bench for the RAM-backed FIFO controller with the RAM model attached.
module tb_nv_ram_rws_512x256_fifo_ctrl;

    localparam int DW = 256;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_pvld = 1'b0;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] wr_pd = '0;
    logic [31:0]   pwrbus_ram_pd = 32'hC0DE_1234;

    logic          wr_prdy;
    logic          rd_pvld;
    logic [DW-1:0] rd_pd;
    logic [9:0]    count;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [31:0]   ram_pwrbus_ram_pd;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];
    int            mdl_cnt = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_pd = '0;

    always #5 clk = ~clk;

    nv_ram_rws_512x256_fifo_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .count             (count),
        .ram_we            (ram_we),
        .ram_wa            (ram_wa),
        .ram_di            (ram_di),
        .ram_re            (ram_re),
        .ram_ra            (ram_ra),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
    );

    nv_ram_rws_512x256 u_ram (
        .clk  (clk),
        .re   (ram_re),
        .ra   (ram_ra),
        .we   (ram_we),
        .wa   (ram_wa),
        .di   (ram_di),
        .dout (ram_dout)
    );

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected words on read handshakes, pushes on accepted
    // writes, tracks occupancy and the hold-while-stalled rule.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_cnt = 0;
            hold_v  = 1'b0;
        end else begin
            check("count_model", count, 256'(mdl_cnt));
            if (hold_v) begin
                check("stall_hold_pvld", rd_pvld, 1);
                check("stall_hold_pd", rd_pd, hold_pd);
            end
            if (rd_pvld && rd_prdy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_pop_empty: got %0h, expected no read", rd_pd);
                end else begin
                    check("sb_data", rd_pd, exp_q.pop_front());
                end
                mdl_cnt--;
            end
            if (wr_pvld && wr_prdy) begin
                exp_q.push_back(wr_pd);
                mdl_cnt++;
            end
            hold_v  = rd_pvld && !rd_prdy;
            hold_pd = rd_pd;
        end
    end

    task automatic single_word(input logic [DW-1:0] d, input string tag);
        @(posedge clk); #1;
        wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1;
        @(negedge clk);
        check({tag, "_c0_ram_re"}, ram_re, 0);
        check({tag, "_c0_wr_prdy"}, wr_prdy, 1);
        check({tag, "_c0_rd_pvld"}, rd_pvld, 0);
        @(posedge clk); #1;
        wr_pvld = 1'b0;
        @(negedge clk);
        check({tag, "_c1_ram_re"}, ram_re, 1);
        check({tag, "_c1_ram_ra"}, ram_ra, 0);
        check({tag, "_c1_rd_pvld"}, rd_pvld, 0);
        @(negedge clk);
        check({tag, "_c2_rd_pvld"}, rd_pvld, 0);
        @(negedge clk);
        check({tag, "_c3_rd_pvld"}, rd_pvld, 1);
        check({tag, "_c3_rd_pd"}, rd_pd, d);
        @(negedge clk);
        check({tag, "_c4_count"}, count, 0);
        check({tag, "_c4_rd_pvld"}, rd_pvld, 0);
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        @(posedge clk); #1;
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        do begin
            @(negedge clk);
            g++;
        end while (count != 0 && g < 1200);
        check(nm, count, 0);
    endtask

    task automatic write_n(input int total, input logic [DW-1:0] base);
        int n;
        int g;
        n = 0;
        g = 0;
        while (n < total && g < 2000) begin
            @(posedge clk); #1;
            wr_pvld = 1'b1;
            wr_pd   = base + DW'(n);
            @(negedge clk);
            if (wr_prdy) n++;
            g++;
        end
    endtask

    initial begin
        // Reset state, with a write offered to prove it is refused.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wr_pvld = 1'b1; wr_pd = {32{8'h11}};
        #1;
        check("rst_wr_prdy", wr_prdy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_rd_pvld", rd_pvld, 0);
        check("rst_rd_pd", rd_pd, 0);
        check("rst_count", count, 0);
        check("pwrbus_pass", ram_pwrbus_ram_pd, 32'hC0DE_1234);
        wr_pvld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single word through an empty FIFO, write and read-ready together.
        single_word({32{8'hA5}}, "single");

        // Fill to 514 with the consumer stalled.
        rd_prdy = 1'b0;
        write_n(514, '0);
        @(posedge clk); #1;
        wr_pvld = 1'b1; wr_pd = {32{8'hEE}}; rd_prdy = 1'b1;
        @(negedge clk);
        check("full_count", count, 514);
        check("full_ram_cnt", dut.ram_cnt_q, 512);
        check("full_out_cnt", dut.out_cnt, 2);
        check("full_wr_refused", wr_prdy, 0);
        check("full_ram_re_on_pop", ram_re, 1);
        @(posedge clk); #1;
        wr_pvld = 1'b0;
        @(negedge clk);
        check("full_wr_prdy_back", wr_prdy, 1);
        check("full_count_after_pop", count, 513);
        drain("fill_drain_done");

        // Streaming at one word per cycle across pointer wrap.
        rd_prdy = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            wr_pvld = 1'b1;
            wr_pd   = {8{32'h1000_0000 + 32'(k)}};
            @(negedge clk);
            check("stream_wr_prdy", wr_prdy, 1);
            if (k >= 3) check("stream_no_gap", rd_pvld, 1);
        end
        drain("stream_drain_done");

        // Random write valid and read ready.
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            wr_pvld = 1'($urandom_range(0, 1));
            rd_prdy = 1'($urandom_range(0, 1));
            for (int w = 0; w < 8; w++) wr_pd[w*32 +: 32] = $urandom();
        end
        drain("random_drain_done");

        // Reset mid-stream with 300 held and a RAM read in flight.
        rd_prdy = 1'b0;
        write_n(301, {32'hBEEF_0000, 224'd0});
        @(posedge clk); #1;
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        @(posedge clk); #1;
        rd_prdy = 1'b0;
        @(negedge clk);
        check("mid_pre_count", count, 300);
        check("mid_pre_inflight", dut.inflight_q, 1);
        #1;
        rst = 1'b1; wr_pvld = 1'b1; wr_pd = {32{8'h77}};
        #1;
        check("mid_rd_pvld", rd_pvld, 0);
        check("mid_rd_pd", rd_pd, 0);
        check("mid_count", count, 0);
        check("mid_wr_prdy", wr_prdy, 0);
        check("mid_ram_re", ram_re, 0);
        check("mid_ram_we", ram_we, 0);
        @(posedge clk);
        @(posedge clk); #1;
        wr_pvld = 1'b0; rst = 1'b0;
        pwrbus_ram_pd = 32'h0000_ABCD;
        @(negedge clk);
        check("post_rst_count", count, 0);
        check("post_rst_rd_pvld", rd_pvld, 0);
        check("post_rst_wr_prdy", wr_prdy, 1);
        check("pwrbus_pass2", ram_pwrbus_ram_pd, 32'h0000_ABCD);
        single_word({32{8'h5A}}, "post_rst");

        @(negedge clk);
        check("sb_left", 256'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
